// File: rtl/dmx_pkg.sv
// dmx_pkg: shared types and constants for the DMX512 transmitter.
// States, the DMX framing constants and a helper that gives the fixed line
// level of each state that does not carry data bits.
package dmx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAB   = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5,
        MTBP  = 3'd6
    } dmx_state_t;

    localparam logic [7:0] DMX_START_CODE = 8'h00;
    localparam int         DMX_STOP_BITS  = 2;
    localparam int         DMX_DATA_BITS  = 8;
    // Width of the bit-period (phase) counter; covers BREAK/MAB/MTBP lengths.
    localparam int         DMX_PH_W       = 16;

    // Line level while in a state with a constant level (DATA is handled by the shifter).
    function automatic logic dmx_state_level(input dmx_state_t s);
        logic lvl;
        case (s)
            BREAK:   lvl = 1'b0;
            START:   lvl = 1'b0;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/dmx_baud_tick.sv
// dmx_baud_tick: free-running CLKS_PER_BIT divider for the DMX bit clock.
// o_bit_tick is high on the final sysclk cycle of every bit period; i_clr
// restarts the period so that a frame begins on a period boundary.
module dmx_baud_tick #(
    parameter int CLKS_PER_BIT = 192
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_clr,
    output logic o_bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_tick = w_last & ~i_clr;

    // Count sysclk cycles within one bit period, wrapping on the last cycle.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr || w_last) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmx_tx_fsm.sv
// dmx_tx_fsm: DMX512 frame transmitter.
// A rising edge on frame_go (while idle) sends BREAK, MAB, the 0x00 start
// code and NUM_SLOTS data bytes read from the channel buffer, each byte as
// one start bit, 8 data bits LSB first and two stop bits.
// Build option DMX_CONT_REFRESH_EN: after each frame hold a mark gap of
// MTBP_BITS periods and restart automatically, forever, after the first edge.
module dmx_tx_fsm
    import dmx_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 250_000,
    parameter int NUM_SLOTS  = 512,
    parameter int BREAK_BITS = 22,
    parameter int MAB_BITS   = 3,
    parameter int MTBP_BITS  = 10,
    localparam int ADDR_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              frame_go,
    input  logic [7:0]        slot_data,
    output logic [ADDR_W-1:0] slot_addr,
    output logic              dmx_tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int SLOT_W       = $clog2(NUM_SLOTS + 1);

    dmx_state_t          r_state;
    dmx_state_t          w_next_state;
    logic [DMX_PH_W-1:0] r_phase;
    logic [DMX_PH_W-1:0] w_phase_nxt;
    logic [DMX_PH_W-1:0] w_len;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          w_load_byte;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_go_q;
    logic                w_start;
    logic                w_bit_tick;
    logic                w_period_end;

    assign w_start     = frame_go & ~r_go_q & (r_state == IDLE);
    assign w_load_byte = (r_slot == {SLOT_W{1'b0}}) ? DMX_START_CODE : slot_data;

    assign slot_addr  = r_addr;
    assign dmx_tx     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

    dmx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .sysclk     (sysclk),
        .reset      (reset),
        .i_clr      (w_start),
        .o_bit_tick (w_bit_tick)
    );

    // Number of bit periods spent in the current state, and end-of-state strobe.
    always_comb begin
        case (r_state)
            BREAK:   w_len = DMX_PH_W'(BREAK_BITS);
            MAB:     w_len = DMX_PH_W'(MAB_BITS);
            START:   w_len = DMX_PH_W'(1);
            DATA:    w_len = DMX_PH_W'(DMX_DATA_BITS);
            STOP:    w_len = DMX_PH_W'(DMX_STOP_BITS);
            MTBP:    w_len = DMX_PH_W'(MTBP_BITS);
            default: w_len = DMX_PH_W'(1);
        endcase
        w_period_end = w_bit_tick & (r_phase == (w_len - DMX_PH_W'(1)));
    end

    // Next-state logic; dmx_tx is computed for the next state so the registered
    // line changes on exactly the same edge as the state.
    always_comb begin
        w_next_state = r_state;
        w_slot_nxt   = r_slot;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_done_nxt   = 1'b0;
        w_addr_nxt   = r_addr;

        if (r_state == IDLE) begin
            w_phase_nxt = {DMX_PH_W{1'b0}};
        end else if (w_period_end) begin
            w_phase_nxt = {DMX_PH_W{1'b0}};
        end else if (w_bit_tick) begin
            w_phase_nxt = r_phase + DMX_PH_W'(1);
        end else begin
            w_phase_nxt = r_phase;
        end

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = BREAK;
                    w_slot_nxt   = {SLOT_W{1'b0}};
                    w_tx_nxt     = dmx_state_level(BREAK);
                end else begin
                    w_tx_nxt     = dmx_state_level(IDLE);
                end
            end
            BREAK: begin
                if (w_period_end) begin
                    w_next_state = MAB;
                    w_tx_nxt     = dmx_state_level(MAB);
                end else begin
                    w_next_state = BREAK;
                end
            end
            MAB: begin
                if (w_period_end) begin
                    w_next_state = START;
                    w_tx_nxt     = dmx_state_level(START);
                end else begin
                    w_next_state = MAB;
                end
            end
            START: begin
                // slot_data has been stable since early in START; latch it now.
                if (w_period_end) begin
                    w_next_state = DATA;
                    w_shift_nxt  = w_load_byte;
                    w_tx_nxt     = w_load_byte[0];
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (w_period_end) begin
                    w_next_state = STOP;
                    w_tx_nxt     = dmx_state_level(STOP);
                end else if (w_bit_tick) begin
                    w_shift_nxt  = {r_shift[0], r_shift[7:1]};
                    w_tx_nxt     = r_shift[1];
                end else begin
                    w_next_state = DATA;
                end
            end
            STOP: begin
                if (w_period_end) begin
                    if (r_slot == SLOT_W'(NUM_SLOTS)) begin
                        w_done_nxt   = 1'b1;
`ifdef DMX_CONT_REFRESH_EN
                        w_next_state = MTBP;
                        w_tx_nxt     = dmx_state_level(MTBP);
`else
                        w_next_state = IDLE;
                        w_tx_nxt     = dmx_state_level(IDLE);
`endif
                    end else begin
                        // Next slot k = r_slot+1 reads buffer[k-1] = buffer[r_slot].
                        w_next_state = START;
                        w_slot_nxt   = r_slot + SLOT_W'(1);
                        w_addr_nxt   = ADDR_W'(r_slot);
                        w_tx_nxt     = dmx_state_level(START);
                    end
                end else begin
                    w_next_state = STOP;
                end
            end
`ifdef DMX_CONT_REFRESH_EN
            MTBP: begin
                if (w_period_end) begin
                    w_next_state = BREAK;
                    w_slot_nxt   = {SLOT_W{1'b0}};
                    w_tx_nxt     = dmx_state_level(BREAK);
                end else begin
                    w_next_state = MTBP;
                end
            end
`endif
            default: begin
                w_next_state = IDLE;
                w_tx_nxt     = 1'b1;
            end
        endcase

        w_busy_nxt = (w_next_state != IDLE);
    end

    // State and output registers; synchronous active-low reset aborts any frame.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_phase <= {DMX_PH_W{1'b0}};
            r_slot  <= {SLOT_W{1'b0}};
            r_shift <= 8'h00;
            r_addr  <= {ADDR_W{1'b0}};
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_go_q  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_phase <= w_phase_nxt;
            r_slot  <= w_slot_nxt;
            r_shift <= w_shift_nxt;
            r_addr  <= w_addr_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_go_q  <= frame_go;
        end
    end

endmodule

// File: tb/tb_dmx_tx_fsm.sv
// tb_dmx_tx_fsm: self-checking bench for dmx_tx_fsm (NUM_SLOTS=4, 192 clk/bit).
// The expected line level at each cycle is derived from the DMX frame layout
// (bit-period index -> BREAK / MAB / slot byte position) using plain arithmetic.
module tb_dmx_tx_fsm;

    localparam int NS    = 4;
    localparam int CPB   = 192;
    localparam int FRAME = (22 + 3 + 11 * (NS + 1)) * CPB;  // 15360
    localparam int GAP   = 10 * CPB;                        // 1920

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_go = 1'b0;
    logic [7:0] slot_data;
    logic [1:0] slot_addr;
    logic       dmx_tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] bufm [0:NS-1];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 sysclk = ~sysclk;

    dmx_tx_fsm #(
        .CLK_HZ     (48_000_000),
        .BAUD       (250_000),
        .NUM_SLOTS  (NS),
        .BREAK_BITS (22),
        .MAB_BITS   (3),
        .MTBP_BITS  (10)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .frame_go   (frame_go),
        .slot_data  (slot_data),
        .slot_addr  (slot_addr),
        .dmx_tx     (dmx_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Channel buffer: synchronous read, data one cycle after address.
    always @(posedge sysclk) slot_data <= bufm[slot_addr];

    task automatic check_val(input string tag, input int cyc, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference line level c cycles after the frame starts.
    function automatic logic exp_tx(input int c);
        int b;
        int j;
        int slot;
        int pos;
        logic [7:0] byt;
        b = c / CPB;
        if (b < 22) return 1'b0;
        if (b < 25) return 1'b1;
        j    = b - 25;
        slot = j / 11;
        pos  = j % 11;
        if (slot > NS) return 1'b1;
        byt = (slot == 0) ? 8'h00 : bufm[slot - 1];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return byt[pos - 1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Check cycles 0..stop_at-1 of a frame; frame_go drops at 50 and re-rises at rego_at.
    task automatic check_frame(input int stop_at, input int rego_at);
        int low_run;
        bit seen_high;
        low_run   = 0;
        seen_high = 1'b0;
        for (int c = 0; c < stop_at; c++) begin
            tick();
            check_val("tx", c, dmx_tx, exp_tx(c));
            check_val("busy", c, busy, 1);
            check_val("done_early", c, frame_done, 0);
            if (!seen_high) begin
                if (dmx_tx) seen_high = 1'b1;
                else low_run++;
            end
            if (c == 50) frame_go = 1'b0;
            if (c == rego_at) frame_go = 1'b1;
        end
        if (stop_at > 4224) check_val("break_len", 0, low_run, 4224);
    endtask

    task automatic end_of_frame_checks(input logic exp_busy);
        tick();
        check_val("done_pulse", FRAME, frame_done, 1);
        check_val("busy_end", FRAME, busy, exp_busy);
        check_val("tx_end", FRAME, dmx_tx, 1);
        check_val("addr_end", FRAME, slot_addr, NS - 1);
        tick();
        check_val("done_width", FRAME + 1, frame_done, 0);
    endtask

    task automatic randomize_buffer();
        for (int i = 0; i < NS; i++) bufm[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        bufm[0] = 8'hA5;
        bufm[1] = 8'h01;
        bufm[2] = 8'hFF;
        bufm[3] = 8'h80;
        reset    = 1'b0;
        frame_go = 1'b0;
        repeat (5) tick();
        check_val("rst_tx", 0, dmx_tx, 1);
        check_val("rst_busy", 0, busy, 0);
        check_val("rst_done", 0, frame_done, 0);
        check_val("rst_addr", 0, slot_addr, 0);
        reset = 1'b1;
        repeat (3) tick();
        check_val("idle_busy", 0, busy, 0);

`ifndef DMX_CONT_REFRESH_EN
        // Frame 1: fixed buffer, extra edge at cycle 6000 must be ignored.
        frame_go = 1'b1;
        check_frame(FRAME, 6000);
        end_of_frame_checks(1'b0);

        // frame_go still held high: no second frame.
        for (int c = 0; c < 300; c++) begin
            tick();
            check_val("hold_busy", c, busy, 0);
            check_val("hold_tx", c, dmx_tx, 1);
        end

        // Frame 2: random buffer, aborted by reset at cycle 8000.
        randomize_buffer();
        frame_go = 1'b0;
        tick();
        frame_go = 1'b1;
        check_frame(8000, -1);
        reset = 1'b0;
        tick();
        check_val("abort_tx", 8000, dmx_tx, 1);
        check_val("abort_busy", 8000, busy, 0);
        check_val("abort_done", 8000, frame_done, 0);
        check_val("abort_addr", 8000, slot_addr, 0);
        reset = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            check_val("post_abort_done", c, frame_done, 0);
            check_val("post_abort_tx", c, dmx_tx, 1);
            check_val("post_abort_busy", c, busy, 0);
        end

        // Frames 3 and 4: random buffers, random ignored re-edge, full length.
        for (int f = 0; f < 2; f++) begin
            randomize_buffer();
            frame_go = 1'b1;
            check_frame(FRAME, 1000 + int'($urandom_range(0, 12000)));
            end_of_frame_checks(1'b0);
            frame_go = 1'b0;
            repeat (3) tick();
        end
`else
        // Continuous refresh: one edge, frames repeat with a mark gap.
        frame_go = 1'b1;
        check_frame(FRAME, 6000);
        end_of_frame_checks(1'b1);
        for (int c = FRAME + 2; c < FRAME + GAP; c++) begin
            tick();
            check_val("gap_tx", c, dmx_tx, 1);
            check_val("gap_busy", c, busy, 1);
            check_val("gap_done", c, frame_done, 0);
        end
        check_frame(FRAME, 3000);
        end_of_frame_checks(1'b1);
        reset = 1'b0;
        tick();
        check_val("cont_abort_busy", 0, busy, 0);
        check_val("cont_abort_tx", 0, dmx_tx, 1);
        reset = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
